// File: rtl/wb_sram.sv
// rtl/wb_sram.sv - Wishbone B4 slave over an inferred byte-enabled synchronous RAM.
// Define WB_SRAM_BURST_EN to add linear incrementing burst support.
module wb_sram #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_STATES = 1,
  parameter int BYTE_SWAP   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic                    we,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic [2:0]              cti,
  input  logic [1:0]              bte,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    ack,
  output logic                    err
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFS = (NB > 1) ? $clog2(NB) : 0;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2, BURST = 2'd3} state_t;

  function automatic logic [DATA_WIDTH-1:0] swap_data(input logic [DATA_WIDTH-1:0] d);
    swap_data = d;
    if (BYTE_SWAP != 0)
      for (int i = 0; i < NB; i++) swap_data[i*8 +: 8] = d[(NB-1-i)*8 +: 8];
  endfunction

  function automatic logic [NB-1:0] swap_sel(input logic [NB-1:0] s);
    swap_sel = s;
    if (BYTE_SWAP != 0)
      for (int i = 0; i < NB; i++) swap_sel[i] = s[NB-1-i];
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_dout;
  logic                  mem_we, mem_re;
  logic [AW-1:0]         mem_widx, mem_ridx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_be;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d, err_q, err_d;
  logic                  we_q, we_d, oor_q, oor_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [31:0] idx;
  logic        in_range, accept;

  assign idx      = addr >> OFS;
  assign in_range = idx < 32'(DEPTH);
  assign accept   = (state_q == IDLE) && cyc && stb && !ack_q && !err_q;

`ifdef WB_SRAM_BURST_EN
  logic        burst_q, burst_d;
  logic [31:0] bidx_q, bidx_d, bidx_next;
  logic        bidx_ok, burst_beat;

  assign bidx_next  = bidx_q + 32'd1;
  assign bidx_ok    = bidx_q < 32'(DEPTH);
  // First beat is answered by the registered ack; later beats ack combinationally on stb.
  assign burst_beat = (state_q == BURST) && !ack_q && cyc && stb;
`else
  logic unused_burst;
  assign unused_burst = ^{cti, bte};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    we_d      = we_q;
    oor_d     = oor_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_widx  = idx[AW-1:0];
    mem_ridx  = idx[AW-1:0];
    mem_wdata = swap_data(wdata);
    mem_be    = swap_sel(sel);
`ifdef WB_SRAM_BURST_EN
    burst_d   = burst_q;
    bidx_d    = bidx_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = we;
          oor_d   = !in_range;
          mem_we  = in_range && we;
          mem_re  = in_range && !we;
          cnt_d   = '0;
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
`ifdef WB_SRAM_BURST_EN
          burst_d = (cti == 3'b010) && (bte == 2'b00);
          bidx_d  = idx + 32'd1;
`endif
        end
      end
      WAIT: begin
        if (!cyc) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'(WAIT_STATES - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (cyc) begin
          ack_d   = !oor_q;
          err_d   = oor_q;
          rdata_d = (oor_q || we_q) ? '0 : swap_data(ram_dout);
`ifdef WB_SRAM_BURST_EN
          if (burst_q && !oor_q) begin
            state_d  = BURST;
            mem_re   = !we_q && bidx_ok;
            mem_ridx = bidx_q[AW-1:0];
          end
`endif
        end
      end
`ifdef WB_SRAM_BURST_EN
      BURST: begin
        if (!cyc) begin
          state_d = IDLE;
        end else if (burst_beat) begin
          if (!bidx_ok) begin
            state_d = IDLE;
          end else begin
            mem_we   = we;
            mem_widx = bidx_q[AW-1:0];
            if (cti == 3'b010) begin
              bidx_d   = bidx_next;
              mem_re   = !we && (bidx_next < 32'(DEPTH));
              mem_ridx = bidx_next[AW-1:0];
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      oor_q   <= 1'b0;
`ifdef WB_SRAM_BURST_EN
      burst_q <= 1'b0;
      bidx_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      oor_q   <= oor_d;
`ifdef WB_SRAM_BURST_EN
      burst_q <= burst_d;
      bidx_q  <= bidx_d;
`endif
    end
  end

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < NB; i++)
        if (mem_be[i]) mem[mem_widx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
    if (mem_re) ram_dout <= mem[mem_ridx];
  end

`ifdef WB_SRAM_BURST_EN
  assign ack   = ack_q || (burst_beat && bidx_ok);
  assign err   = err_q || (burst_beat && !bidx_ok);
  assign rdata = (burst_beat && bidx_ok && !we) ? swap_data(ram_dout) : rdata_q;
`else
  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;
`endif
endmodule

// File: tb/tb_wb_sram.sv
// tb/tb_wb_sram.sv - directed self-checking bench for wb_sram (swapped and straight instances).
module tb_wb_sram;
  logic        clk, reset;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] rdata, rdata0;
  logic        ack, err, ack0, err0;

  int checks = 0;
  int fails  = 0;

  wb_sram #(.DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(1), .BYTE_SWAP(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .sel(sel), .we(we),
    .cyc(cyc), .stb(stb), .cti(cti), .bte(bte), .rdata(rdata), .ack(ack), .err(err));

  wb_sram #(.DATA_WIDTH(32), .DEPTH(16), .WAIT_STATES(1), .BYTE_SWAP(0)) dut0 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .sel(sel), .we(we),
    .cyc(cyc), .stb(stb), .cti(cti), .bte(bte), .rdata(rdata0), .ack(ack0), .err(err0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One classic transfer; lat = clock edges from accept to the edge that raised ack/err.
  task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic w, output int lat, output logic [31:0] rd,
                      output logic [31:0] rd0, output logic ak, output logic er);
    @(negedge clk);
    addr = a; wdata = d; sel = s; we = w; cti = 3'b000; bte = 2'b00;
    cyc = 1'b1; stb = 1'b1;
    lat = -1; rd = '0; rd0 = '0; ak = 1'b0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack || err) begin
        lat = n - 1; rd = rdata; rd0 = rdata0; ak = ack; er = err;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  int          lat, acks, first_n, second_n, seen;
  logic [31:0] rd, rd0;
  logic        ak, er;
`ifdef WB_SRAM_BURST_EN
  int          beat;
  int          pos [4];
  logic [31:0] bexp [4];
`endif

  initial begin
    reset = 1'b1; addr = '0; wdata = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cti = '0; bte = '0;
    repeat (2) @(negedge clk);
    chk("reset_ack", 32'(ack), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    reset = 1'b0;

    // Classic write/read, one wait state
    xfer(32'h10, 32'h11223344, 4'hF, 1'b1, lat, rd, rd0, ak, er);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_rdata_zero", rd, 32'h0);
    chk("wr_ack", 32'(ak), 32'd1);
    chk("mem_swapped", dut.mem[4], 32'h44332211);
    chk("mem_straight", dut0.mem[4], 32'h11223344);
    xfer(32'h10, 32'h0, 4'h0, 1'b0, lat, rd, rd0, ak, er);
    chk("rd_latency", 32'(lat), 32'd2);
    chk("rd_data", rd, 32'h11223344);
    chk("rd_data_noswap", rd0, 32'h11223344);

    // Partial write over all-ones
    xfer(32'h20, 32'hFFFFFFFF, 4'hF, 1'b1, lat, rd, rd0, ak, er);
    xfer(32'h20, 32'h0000AB00, 4'b0010, 1'b1, lat, rd, rd0, ak, er);
    xfer(32'h20, 32'h0, 4'h0, 1'b0, lat, rd, rd0, ak, er);
    chk("partial_noswap", rd0, 32'hFFFFABFF);
    chk("partial_swap", rd, 32'hFFFFABFF);
    chk("partial_mem_swap", dut.mem[8], 32'hFFABFFFF);

    // Out of range read at DEPTH*NB
    xfer(32'h0, 32'hCAFEF00D, 4'hF, 1'b1, lat, rd, rd0, ak, er);
    xfer(32'd64, 32'h0, 4'h0, 1'b0, lat, rd, rd0, ak, er);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_ack", 32'(ak), 32'd0);
    chk("oor_latency", 32'(lat), 32'd2);
    @(negedge clk);
    chk("oor_err_one_cycle", 32'(err), 32'd0);
    xfer(32'h0, 32'h0, 4'h0, 1'b0, lat, rd, rd0, ak, er);
    chk("after_oor_rd", rd, 32'hCAFEF00D);

    // Back-to-back reads with stb held across ack
    @(negedge clk);
    addr = 32'h10; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    acks = 0; first_n = -1; second_n = -1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (ack) begin
        acks++;
        if (acks == 1) first_n = n;
        else begin
          second_n = n;
          chk("b2b_data", rdata, 32'h11223344);
          cyc = 1'b0; stb = 1'b0;
          break;
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_acks", 32'(acks), 32'd2);
    chk("b2b_first", 32'(first_n), 32'd3);
    chk("b2b_second", 32'(second_n), 32'd7);

    // Reset pulse during WAIT
    @(negedge clk);
    addr = 32'h10; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    reset = 1'b1;
    #2 reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack || err) seen++;
    end
    cyc = 1'b0;
    chk("reset_wait_no_resp", 32'(seen), 32'd0);
    xfer(32'h10, 32'h0, 4'h0, 1'b0, lat, rd, rd0, ak, er);
    chk("post_reset_latency", 32'(lat), 32'd2);
    chk("post_reset_data", rd, 32'h11223344);

    // cyc dropped during WAIT of a write
    @(negedge clk);
    addr = 32'h24; wdata = 32'h5A5A5A5A; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack || err) seen++;
    end
    chk("abort_no_resp", 32'(seen), 32'd0);
    xfer(32'h24, 32'h0, 4'h0, 1'b0, lat, rd, rd0, ak, er);
    chk("abort_latency", 32'(lat), 32'd2);
    chk("abort_write_kept", rd, 32'h5A5A5A5A);

`ifdef WB_SRAM_BURST_EN
    bexp[0] = 32'hA0A0A0A0; bexp[1] = 32'hB1B1B1B1;
    bexp[2] = 32'hC2C2C2C2; bexp[3] = 32'hD3D3D3D3;
    for (int i = 0; i < 4; i++) xfer(32'(i * 4), bexp[i], 4'hF, 1'b1, lat, rd, rd0, ak, er);
    @(negedge clk);
    addr = 32'h0; we = 1'b0; sel = 4'hF; cti = 3'b010; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    beat = 0;
    for (int i = 0; i < 4; i++) pos[i] = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (ack) begin
        chk("burst_data", rdata, bexp[beat]);
        pos[beat] = n;
        beat++;
        if (beat == 4) break;
        addr = 32'(beat * 4);
        cti  = (beat == 3) ? 3'b111 : 3'b010;
      end
    end
    cyc = 1'b0; stb = 1'b0; cti = 3'b000;
    chk("burst_beats", 32'(beat), 32'd4);
    chk("burst_consec1", 32'(pos[2] - pos[1]), 32'd1);
    chk("burst_consec2", 32'(pos[3] - pos[2]), 32'd1);
    @(negedge clk);
    chk("burst_idle_ack", 32'(ack), 32'd0);
    xfer(32'h4, 32'h0, 4'h0, 1'b0, lat, rd, rd0, ak, er);
    chk("burst_after_latency", 32'(lat), 32'd2);
    chk("burst_after_data", rd, 32'hB1B1B1B1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
